// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the IF / EXE-MEM memory-port arbiter.
// Requester IDs, default sizing, and the muxed request bundle.
package sram_like_arbiter_pkg;

    localparam logic ARB_ID_INST = 1'b0;
    localparam logic ARB_ID_DATA = 1'b1;

    localparam int ARB_OUTSTANDING_DEF  = 2;
    localparam int ARB_STARVE_LIMIT_DEF = 4;

    typedef struct packed {
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } arb_req_t;

    function automatic int arb_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order tracker of requester IDs for outstanding memory transactions.
// Full/empty come from the occupancy count, so any depth (not just 2^n) works.
module arb_id_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter  int DEPTH = ARB_OUTSTANDING_DEF,
    localparam int PTR_W = arb_ptr_w(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_id,
    input  logic             pop,
    output logic             head_id,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_id = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like port between instruction and data requesters,
// holding a stalled grant and routing in-order responses by issue ID.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int OUTSTANDING  = ARB_OUTSTANDING_DEF,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    logic          hold_valid_q, hold_valid_d;
    logic          hold_id_q, hold_id_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;

    logic             grant_id, granted_req, fifo_full, fifo_empty;
    logic             push, pop, head_id;
    logic [CNT_W-1:0] fifo_count;
    arb_req_t         inst_r, data_r, gnt_r;

    assign inst_r = '{wr: inst_wr, wstrb: inst_wstrb, addr: inst_addr, wdata: inst_wdata};
    assign data_r = '{wr: data_wr, wstrb: data_wstrb, addr: data_addr, wdata: data_wdata};

    always_comb begin
        if (hold_valid_q)
            grant_id = hold_id_q;
        else if (starve_cnt_q == SW'(STARVE_LIMIT) && inst_req)
            grant_id = ARB_ID_INST;
        else if (data_req)
            grant_id = ARB_ID_DATA;
        else
            grant_id = ARB_ID_INST;
    end

    assign granted_req = (grant_id == ARB_ID_DATA) ? data_req : inst_req;
    assign gnt_r       = (grant_id == ARB_ID_DATA) ? data_r : inst_r;

    // Full is taken from the registered count only, keeping mem_data_ok off the request path.
    assign fifo_full  = (fifo_count == CNT_W'(OUTSTANDING));
    assign fifo_empty = (fifo_count == '0);

    assign mem_req   = granted_req & ~fifo_full;
    assign mem_wr    = gnt_r.wr;
    assign mem_wstrb = gnt_r.wstrb;
    assign mem_addr  = gnt_r.addr;
    assign mem_wdata = gnt_r.wdata;

    assign push = mem_req & mem_addr_ok;
    assign pop  = mem_data_ok & ~fifo_empty;

    assign inst_addr_ok = push & (grant_id == ARB_ID_INST);
    assign data_addr_ok = push & (grant_id == ARB_ID_DATA);
    assign inst_data_ok = pop & (head_id == ARB_ID_INST);
    assign data_data_ok = pop & (head_id == ARB_ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_id_d    = hold_id_q;
        if (mem_req && !mem_addr_ok) begin
            hold_valid_d = 1'b1;
            hold_id_d    = grant_id;
        end else if (push) begin
            hold_valid_d = 1'b0;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!inst_req || inst_addr_ok)
            starve_cnt_d = '0;
        else if (data_addr_ok && starve_cnt_q != SW'(STARVE_LIMIT))
            starve_cnt_d = starve_cnt_q + SW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            hold_id_q    <= ARB_ID_INST;
            starve_cnt_q <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_id_q    <= hold_id_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    arb_id_fifo #(.DEPTH(OUTSTANDING)) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .push_id (grant_id),
        .pop     (pop),
        .head_id (head_id),
        .count   (fifo_count)
    );

endmodule
